pipelined_barrel_shifter: RTL and testbench

- Parametrised, fully pipelined shifter/rotator for WIDTH-bit operands.
- Offers logical, arithmetic and rotate modes in both directions.
- Uses a valid/ready handshake on both sides and accepts one operand per cycle.
- Sits between the operand-select logic and the writeback mux of the datapath, replacing the fixed 8-bit combinational shifter.
- Built as log2(WIDTH) cascaded shift stages, each followed by a register slice.

---
 rtl/shifter_pkg.sv | 15 +
 rtl/shift_stage.sv | 91 +++++++++
 rtl/pipelined_barrel_shifter.sv | 76 +++++++
 tb/tb_pipelined_barrel_shifter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the pipelined shifter: shift modes and direction constants.
// Imported by the top and by every shift stage.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_LOGICAL  = 2'd0,
        SH_ARITH    = 2'd1,
        SH_ROTATE   = 2'd2,
        SH_RESERVED = 2'd3
    } sh_mode_e;

    localparam logic SH_LEFT  = 1'b1;
    localparam logic SH_RIGHT = 1'b0;

endpackage

// File: rtl/shift_stage.sv
// One shifter stage: conditionally shifts/rotates by DIST, then registers result and control.
// Latency 1 cycle; loads when empty or when downstream drains it in the same cycle.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_dir,
    output logic [1:0]       out_mode
);

    localparam int BIT = $clog2(DIST);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stage_res;
    logic             load;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    logic             dir_q;
    logic [1:0]       mode_q;

    always_comb begin
        shifted = in_data;
        case (sh_mode_e'(in_mode))
            SH_ROTATE: begin
                if (in_dir == SH_LEFT)
                    shifted = (in_data << DIST) | (in_data >> (WIDTH - DIST));
                else
                    shifted = (in_data >> DIST) | (in_data << (WIDTH - DIST));
            end
            // Sign fill only matters for right shifts; left arithmetic is logical left.
            SH_ARITH: begin
                if (in_dir == SH_LEFT)
                    shifted = in_data << DIST;
                else
                    shifted = WIDTH'($signed(in_data) >>> DIST);
            end
            default: begin
                if (in_dir == SH_LEFT)
                    shifted = in_data << DIST;
                else
                    shifted = in_data >> DIST;
            end
        endcase
        stage_res = in_shamt[BIT] ? shifted : in_data;
    end

    assign load     = !valid_q || out_ready;
    assign in_ready = !rst && load;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'd0;
        end else if (load) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q  <= stage_res;
                shamt_q <= in_shamt;
                dir_q   <= in_dir;
                mode_q  <= in_mode;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_dir   = dir_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined WIDTH-bit shifter/rotator, one register slice per shift-amount bit, MSB amount first.
// Latency log2(WIDTH) cycles; valid/ready both sides, empty slots let upstream advance under stall.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Index k is the input of stage k; index k+1 is its registered output.
    logic [SHW:0]     vld;
    logic [WIDTH-1:0] dat [SHW+1];
    logic [SHW-1:0]   sha [SHW+1];
    logic [SHW:0]     dir;
    logic [1:0]       mde [SHW+1];
    logic [SHW-1:0]   dn_rdy;
    logic [SHW-1:0]   stg_in_rdy;

    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign sha[0] = in_shamt;
    assign dir[0] = in_dir;
    assign mde[0] = in_mode;

    // Ready is resolved in one flat pass from the output backwards so the
    // chain forms no combinational loop through the stage instances.
    always_comb begin
        dn_rdy = '0;
        dn_rdy[SHW-1] = out_ready;
        for (int k = SHW - 2; k >= 0; k--) begin
            dn_rdy[k] = !vld[k+2] || dn_rdy[k+1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << (SHW - 1 - k))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[k]),
            .in_ready  (stg_in_rdy[k]),
            .in_data   (dat[k]),
            .in_shamt  (sha[k]),
            .in_dir    (dir[k]),
            .in_mode   (mde[k]),
            .out_valid (vld[k+1]),
            .out_ready (dn_rdy[k]),
            .out_data  (dat[k+1]),
            .out_shamt (sha[k+1]),
            .out_dir   (dir[k+1]),
            .out_mode  (mde[k+1])
        );
    end

    assign in_ready  = stg_in_rdy[0];
    assign out_valid = vld[SHW];
    assign out_data  = dat[SHW];

    logic unused_tail;
    assign unused_tail = ^{sha[SHW], dir[SHW], mde[SHW], stg_in_rdy};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed table and corner sequences at WIDTH=8,
// then randomized traffic at WIDTH=8/16/32 against an arithmetic reference model.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rand_go = 1'b0;

    // Directed DUT signals (WIDTH = 8)
    logic       iv, ir, idir, ov, ordy;
    logic [7:0] idat, odat;
    logic [2:0] ish;
    logic [1:0] imode;

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv), .in_ready(ir), .in_data(idat), .in_shamt(ish),
        .in_dir(idir), .in_mode(imode),
        .out_valid(ov), .out_ready(ordy), .out_data(odat)
    );

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on a 64-bit value masked to w bits.
    function automatic longint unsigned ref_shift(input longint unsigned d, input int s,
                                                  input bit left, input int mode, input int w);
        longint unsigned mask, r;
        mask = (64'd1 << w) - 64'd1;
        d = d & mask;
        if (mode == 2) begin
            if (s == 0) r = d;
            else if (left) r = ((d << s) | (d >> (w - s))) & mask;
            else r = ((d >> s) | (d << (w - s))) & mask;
        end else if (mode == 1 && !left) begin
            r = d >> s;
            if (((d >> (w - 1)) & 64'd1) == 64'd1) r = r | (mask & ~(mask >> s));
        end else begin
            r = left ? ((d << s) & mask) : (d >> s);
        end
        return r;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic [2:0] sh;
        logic       dir;
        logic [1:0] mode;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n, got, accepted, stale;
        logic [7:0] held;
        logic [7:0] bd [8];
        logic [7:0] bq [$];
        logic [7:0] sq [$];

        rst = 1'b1; iv = 1'b0; idat = '0; ish = '0; idir = 1'b0; imode = 2'd0; ordy = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", ov, 0);
        chk("reset_out_data", odat, 0);
        chk("reset_in_ready", ir, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", ir, 1);

        tbl.push_back('{8'hB5, 3'd3, 1'b1, 2'd0, 8'hA8});
        tbl.push_back('{8'hB5, 3'd3, 1'b0, 2'd0, 8'h16});
        tbl.push_back('{8'hB5, 3'd3, 1'b0, 2'd1, 8'hF6});
        tbl.push_back('{8'hB5, 3'd3, 1'b1, 2'd1, 8'hA8});
        tbl.push_back('{8'hB5, 3'd3, 1'b1, 2'd2, 8'hAD});
        tbl.push_back('{8'hB5, 3'd3, 1'b0, 2'd2, 8'hB6});
        for (int m = 0; m < 4; m++)
            for (int dr = 0; dr < 2; dr++)
                tbl.push_back('{8'h5A, 3'd0, 1'(dr), 2'(m), 8'h5A});
        tbl.push_back('{8'h80, 3'd7, 1'b0, 2'd0, 8'h01});
        tbl.push_back('{8'h80, 3'd7, 1'b0, 2'd1, 8'hFF});
        tbl.push_back('{8'h01, 3'd7, 1'b1, 2'd2, 8'h80});
        tbl.push_back('{8'h81, 3'd1, 1'b0, 2'd3, 8'h40});
        tbl.push_back('{8'h81, 3'd1, 1'b1, 2'd1, 8'h02});

        foreach (tbl[i]) begin
            @(negedge clk);
            idat = tbl[i].d; ish = tbl[i].sh; idir = tbl[i].dir; imode = tbl[i].mode; iv = 1'b1;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), ir, 1);
            @(negedge clk);
            iv = 1'b0;
            n = 1;
            while (!ov && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("tbl%0d_latency", i), n, 3);
            chk($sformatf("tbl%0d_data", i), odat, tbl[i].exp);
        end

        // Back-to-back: eight operands on consecutive cycles
        for (int i = 0; i < 8; i++) bd[i] = 8'($urandom);
        bq.delete();
        for (int i = 0; i < 8; i++)
            bq.push_back(8'(ref_shift(64'(bd[i]), i, 1'(i % 2), i % 4, 8)));
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    idat = bd[i]; ish = 3'(i); idir = 1'(i % 2); imode = 2'(i % 4); iv = 1'b1;
                    @(negedge clk);
                end
                iv = 1'b0;
            end
            begin
                got = 0;
                for (int c = 1; c <= 14; c++) begin
                    @(negedge clk);
                    if (ov) begin
                        chk($sformatf("b2b%0d_cycle", got), c, 3 + got);
                        if (got < 8) chk($sformatf("b2b%0d_data", got), odat, bq[got]);
                        got++;
                    end
                end
                chk("b2b_count", got, 8);
            end
        join

        // Stall: output blocked for six feeding cycles
        @(negedge clk);
        ordy = 1'b0;
        accepted = 0;
        sq.delete();
        for (int c = 0; c < 6; c++) begin
            idat = 8'($urandom); ish = 3'($urandom); idir = 1'($urandom); imode = 2'($urandom);
            iv = 1'b1;
            #1;
            if (ir) begin
                sq.push_back(8'(ref_shift(64'(idat), int'(ish), idir, int'(imode), 8)));
                accepted++;
            end
            @(negedge clk);
        end
        chk("stall_accept_count", accepted, 3);
        chk("stall_in_ready_low", ir, 0);
        chk("stall_out_valid", ov, 1);
        held = odat;
        repeat (2) @(negedge clk);
        chk("stall_data_hold", odat, held);
        iv = 1'b0;
        ordy = 1'b1;
        #1;
        chk("stall_ready_rise", ir, 1);
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (ov) begin
                if (sq.size() > 0) chk($sformatf("stall_drain%0d", got), odat, sq.pop_front());
                else chk("stall_extra_result", 1, 0);
                got++;
            end
            @(negedge clk);
            #1;
        end
        chk("stall_drain_count", got, 3);

        // Reset with two operands in flight
        @(negedge clk);
        idat = 8'hC3; ish = 3'd2; idir = 1'b0; imode = 2'd1; iv = 1'b1;
        @(negedge clk);
        idat = 8'h3C; ish = 3'd1;
        @(negedge clk);
        iv = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", ir, 0);
        @(negedge clk);
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data", odat, 0);
        rst = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov) stale++;
        end
        chk("rst_no_stale", stale, 0);

        rand_go = 1'b1;
        wait (g[0].done && g[1].done && g[2].done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int W  = 8 << gi;
        localparam int SW = $clog2(W);
        localparam int NOPS = 10000;
        localparam int BUDGET = 40000;

        logic          in_valid, in_ready, in_dir, out_valid, out_ready;
        logic [W-1:0]  in_data, out_data;
        logic [SW-1:0] in_shamt;
        logic [1:0]    in_mode;
        bit            done;
        logic [W-1:0]  q [$];

        pipelined_barrel_shifter #(.WIDTH(W)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
            .in_dir(in_dir), .in_mode(in_mode),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
        );

        initial begin
            int sent, cyc, recv;
            done = 1'b0;
            in_valid = 1'b0; in_data = '0; in_shamt = '0; in_dir = 1'b0; in_mode = 2'd0;
            out_ready = 1'b1;
            wait (rand_go);
            sent = 0; cyc = 0; recv = 0;
            while ((sent < NOPS || q.size() > 0) && cyc < BUDGET) begin
                @(negedge clk);
                cyc++;
                in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                in_data   = W'($urandom);
                in_shamt  = SW'($urandom_range(0, W - 1));
                in_dir    = 1'($urandom);
                in_mode   = 2'($urandom);
                out_ready = (sent >= NOPS) || ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid && out_ready) begin
                    if (q.size() > 0) chk($sformatf("rand_w%0d_res%0d", W, recv), out_data, q.pop_front());
                    else chk($sformatf("rand_w%0d_spurious", W), 1, 0);
                    recv++;
                end
                if (in_valid && in_ready) begin
                    q.push_back(W'(ref_shift(64'(in_data), int'(in_shamt), in_dir, int'(in_mode), W)));
                    sent++;
                end
            end
            chk($sformatf("rand_w%0d_timeout", W), (cyc >= BUDGET) ? 1 : 0, 0);
            chk($sformatf("rand_w%0d_count", W), recv, NOPS);
            in_valid = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
